if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Decoupling instruction queue directly downstream of the fetch stage, feeding decode.
- Captures {PC, instruction} pairs each cycle fetch reports a completed read, and presents them in order to decode through a valid/ready handshake.
- Drives the fetch stall input when full. Discards all buffered entries on a branch flush.
- When empty, decode sees a NOP.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  fetch has a valid instruction this cycle (fetch Done and not flushed)
- in_pc  input  32  PC of the incoming instruction
- in_instr  input  32  incoming instruction word
- in_ready  output  1  queue can accept this cycle; fetch stall = ~in_ready
- flush  input  1  branch/interrupt redirect; discard queue contents
- out_ready  input  1  decode consumes the head entry this cycle
- out_valid  output  1  head entry valid
- out_pc  output  32  PC of head entry (0 when empty)
- out_instr  output  32  head instruction (IQ_NOP when empty)
- count  output  PTR_W+1  number of valid entries, 0..DEPTH

Behaviour:
- Reset (asynchronous, active-low):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=IQ_NOP.
  - Storage array is not reset.
- Push:
  - Occurs when in_valid & in_ready & ~flush.
  - Writes mem[wr_ptr] at the clock edge; wr_ptr increments and wraps DEPTH-1 -> 0.
- Pop:
  - Occurs when out_valid & out_ready & ~flush.
  - rd_ptr increments with the same wrap rule.
- Output datapath:
  - out_valid = (count != 0).
  - out_pc / out_instr are combinational from mem[rd_ptr] when out_valid, otherwise 0 / IQ_NOP.
- Latency:
  - An instruction pushed at edge N is visible at the output after edge N (1 cycle).
  - No same-cycle bypass when empty.
- in_ready:
  - in_ready = (count < DEPTH) | (out_valid & out_ready).
  - When full, a simultaneous pop frees a slot, so push and pop in the same cycle keep count constant and no bubble is inserted.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Both or neither: unchanged.
- Full boundary: count==DEPTH with no pop gives in_ready=0, and fetch holds its PC.
- Empty boundary:
  - out_ready while empty is ignored; no pointer movement.
  - count never underflows.
- Flush:
  - Synchronous. At the next edge rd_ptr=wr_ptr=0 and count=0.
  - The push and pop offered in the flush cycle are both discarded.
  - During the flush cycle in_ready=1 and out_valid still reflects the pre-flush count, but decode must treat the head as squashed; the decode stage owns that squash.
- Flush takes priority over push and pop. Reset takes priority over everything.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of the clock.
- Illegal: in_valid asserted while in_ready=0. The entry is dropped, state is unchanged, and a simulation-only assertion fires.
- Assertion (simulation only): count must equal (wr_ptr - rd_ptr) mod DEPTH, with the full/empty distinction taken from count.

Decomposition:
- Package iq_pkg holds:
  - IQ_NOP = 32'h7800_0000 (opcode 5'b01111, remaining bits 0).
  - typedef struct packed { logic [31:0] pc; logic [31:0] instr; } iq_entry_t.
- One sub-module, iq_storage: DEPTH x iq_entry_t register array with one write port (we, waddr, wdata) and one combinational read port (raddr -> rdata).
- Pointers, count, handshake and flush logic stay in if_id_queue.

Test Plan:
- Reset, then idle -> out_valid=0, out_instr=32'h7800_0000, out_pc=0, in_ready=1, count=0.
- Push PCs 0x0, 0x4, 0x8 with out_ready=0 -> count 1,2,3 on successive edges; head stays pc=0x0; then pop 3 -> outputs in order 0x0, 0x4, 0x8; count returns to 0.
- Push 4 with out_ready=0 -> count=4, in_ready=0; a 5th in_valid held is not accepted; next cycle out_ready=1 with in_valid=1 -> in_ready=1, count stays 4, head advances to second entry.
- Continuous push+pop for 10 cycles at DEPTH=4 -> pointers wrap twice, every PC appears exactly once in order, count stays 1.
- Queue holds 3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_instr=IQ_NOP; the flush-cycle instruction is never output.
- Assert rst_n low between edges while count=2 -> count=0 and out_valid=0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package iq_pkg;

    // Bubble presented to decode whenever the queue is empty (opcode 5'b01111).
    localparam logic [31:0] IQ_NOP = 32'h7800_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue; master drives fetch side and decode ready.
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             flush;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/if_id_queue_storage.sv
// Entry storage for the instruction queue: one synchronous write port, one combinational read port.
module iq_storage
    import iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  iq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output iq_entry_t        rdata
);

    iq_entry_t mem [DEPTH];

    // Contents are deliberately left unreset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Decoupling queue between fetch and decode: in-order {pc, instr} buffer with stall, flush and NOP fill.
module if_id_queue
    import iq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_queue_if.slave q
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;
    iq_entry_t        wdata;
    iq_entry_t        rdata;

    assign wdata = '{pc: q.in_pc, instr: q.in_instr};

    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // A pop while full frees the slot for a same-cycle push, so streaming never bubbles.
    assign q.out_valid = (cnt != '0);
    assign q.in_ready  = q.flush | (cnt != FULL_CNT) | (q.out_valid & q.out_ready);
    assign q.out_pc    = q.out_valid ? rdata.pc    : 32'h0;
    assign q.out_instr = q.out_valid ? rdata.instr : IQ_NOP;
    assign q.count     = cnt;

    assign push = q.in_valid  & q.in_ready  & ~q.flush;
    assign pop  = q.out_valid & q.out_ready & ~q.flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (q.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Simulation checks: pointer distance agrees with count, and fetch honours the stall.
    logic [PTR_W-1:0] ptr_diff;
    assign ptr_diff = wr_ptr - rd_ptr;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (ptr_diff == cnt[PTR_W-1:0] && cnt <= FULL_CNT)
                else $error("if_id_queue: pointer distance %0d disagrees with count %0d", ptr_diff, cnt);
            assert (!(q.in_valid && !q.in_ready))
                else $warning("if_id_queue: in_valid while in_ready low, entry dropped");
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed and randomized bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
    import iq_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    iq_entry_t   mq[$];
    logic [31:0] popped[$];

    if_id_queue_if #(.DEPTH(DEPTH)) q ();

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_assert++;
        assert (obs === req)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h required %0h", tag, obs, req);
            end
    endtask

    task automatic check_outputs(input logic ordy, input logic fl);
        int  sz;
        bit  exp_rdy;
        sz      = mq.size();
        exp_rdy = fl || (sz < DEPTH) || (sz > 0 && ordy);
        chk("count",     64'(q.count),     64'(sz));
        chk("out_valid", 64'(q.out_valid), 64'(sz != 0));
        chk("out_pc",    64'(q.out_pc),    64'(sz != 0 ? mq[0].pc : 32'h0));
        chk("out_instr", 64'(q.out_instr), 64'(sz != 0 ? mq[0].instr : IQ_NOP));
        chk("in_ready",  64'(q.in_ready),  64'(exp_rdy));
    endtask

    // Called just after the posedge that consumed this cycle's inputs.
    task automatic model_update(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                                input logic ordy, input logic fl);
        bit do_pop;
        bit do_push;
        if (fl) begin
            mq.delete();
        end else begin
            do_pop  = ordy && (mq.size() > 0);
            do_push = v && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                popped.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (do_push) mq.push_back('{pc: pc, instr: ins});
        end
    endtask

    // Entered and left at posedge+1.
    task automatic step(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        logic [31:0] ins;
        ins         = $urandom;
        q.in_valid  = v;
        q.in_pc     = pc;
        q.in_instr  = ins;
        q.out_ready = ordy;
        q.flush     = fl;
        #2;
        check_outputs(ordy, fl);
        @(posedge clk);
        model_update(v, pc, ins, ordy, fl);
        #1;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        q.in_valid  = 1'b0;
        q.in_pc     = '0;
        q.in_instr  = '0;
        q.out_ready = 1'b0;
        q.flush     = 1'b0;

        #2;
        chk("rst_out_valid", 64'(q.out_valid), 64'(0));
        chk("rst_out_instr", 64'(q.out_instr), 64'h7800_0000);
        chk("rst_out_pc",    64'(q.out_pc),    64'(0));
        chk("rst_in_ready",  64'(q.in_ready),  64'(1));
        chk("rst_count",     64'(q.count),     64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0);

        // Fill three, then drain in order.
        for (int i = 0; i < 3; i++) step(1, 32'(4 * i), 0, 0);
        chk("fill3_count", 64'(q.count), 64'(3));
        chk("fill3_head",  64'(q.out_pc), 64'(0));
        popped.delete();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("drain3_n", 64'(popped.size()), 64'(3));
        for (int i = 0; i < 3; i++) chk("drain3_order", 64'(popped[i]), 64'(4 * i));
        step(0, 0, 0, 0);

        // Full boundary, held push while stalled, then push+pop at full.
        for (int i = 0; i < 4; i++) step(1, 32'h10 + 32'(4 * i), 0, 0);
        chk("full_count",    64'(q.count),    64'(4));
        chk("full_in_ready", 64'(q.in_ready), 64'(0));
        step(1, 32'h20, 0, 0);
        chk("held_count", 64'(q.count),  64'(4));
        chk("held_head",  64'(q.out_pc), 64'h10);
        step(1, 32'h20, 1, 0);
        chk("pp_full_count", 64'(q.count),  64'(4));
        chk("pp_full_head",  64'(q.out_pc), 64'h14);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Streaming push+pop across two pointer wraps.
        step(1, 32'h100, 0, 0);
        popped.delete();
        for (int i = 1; i <= 10; i++) begin
            step(1, 32'h100 + 32'(4 * i), 1, 0);
            chk("stream_count", 64'(q.count), 64'(1));
        end
        chk("stream_n", 64'(popped.size()), 64'(10));
        for (int i = 0; i < 10; i++) chk("stream_order", 64'(popped[i]), 64'(32'h100 + 32'(4 * i)));
        step(0, 0, 1, 0);

        // Flush with push and pop offered in the same cycle.
        for (int i = 0; i < 3; i++) step(1, 32'h200 + 32'(4 * i), 0, 0);
        popped.delete();
        step(1, 32'h20c, 1, 1);
        chk("flush_count",     64'(q.count),     64'(0));
        chk("flush_out_valid", 64'(q.out_valid), 64'(0));
        chk("flush_out_instr", 64'(q.out_instr), 64'h7800_0000);
        chk("flush_no_pop",    64'(popped.size()), 64'(0));
        step(0, 0, 1, 0);

        // Asynchronous reset between edges.
        step(1, 32'h300, 0, 0);
        step(1, 32'h304, 0, 0);
        q.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count",     64'(q.count),     64'(0));
        chk("arst_out_valid", 64'(q.out_valid), 64'(0));
        mq.delete();
        #1 rst_n = 1'b1;
        #1;
        chk("arst_in_ready", 64'(q.in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Randomized traffic; fetch only offers when the queue can accept.
        for (int c = 0; c < 300; c++) begin
            logic ordy;
            logic fl;
            logic v;
            bit   can;
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 15) == 0);
            can  = fl || (mq.size() < DEPTH) || (mq.size() > 0 && ordy);
            v    = can && ($urandom_range(0, 3) != 0);
            step(v, 32'h1000 + 32'(4 * c), ordy, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
